// File: rtl/sram_256x4_if.sv
// Bus interface for the 256x4 single-port SRAM.
// It groups write data, address, write enable and registered read data.
interface sram_256x4_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] dat_in;
  logic [ADDR_W-1:0] addr_in;
  logic              w_en;
  logic [DATA_W-1:0] read_d;

  // The requester drives the request fields and samples the read data.
  modport master (
    output dat_in,
    output addr_in,
    output w_en,
    input  read_d
  );

  // The memory samples the request fields and drives the read data.
  modport slave (
    input  dat_in,
    input  addr_in,
    input  w_en,
    output read_d
  );
endinterface

// File: rtl/sram_256x4.sv
// Single-port synchronous SRAM, 256 words x 4 bits, built from registers.
// Writes are write-first: on a write edge, read_d takes the written data.
// On a read edge, read_d takes the addressed word one cycle after the address.
// The asynchronous active-low reset clears the whole array and read_d.
module sram_256x4 #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  sram_256x4_if.slave   bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] read_d_q;
  logic [DATA_W-1:0] read_d_d;

  // Next array contents: only the addressed word changes on a write.
  always_comb begin
    mem_d = mem_q;
    if (bus.w_en) begin
      mem_d[bus.addr_in] = bus.dat_in;
    end else begin
      mem_d = mem_q;
    end
  end

  // Next read data: write-through on a write, stored word on a read.
  always_comb begin
    read_d_d = {DATA_W{1'b0}};
    if (bus.w_en) begin
      read_d_d = bus.dat_in;
    end else begin
      read_d_d = mem_q[bus.addr_in];
    end
  end

  // Array and read register: cleared by async reset, updated every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      read_d_q <= {DATA_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      read_d_q <= read_d_d;
    end
  end

  assign bus.read_d = read_d_q;
endmodule

// File: tb/tb_sram_256x4.sv
// Self-checking bench for sram_256x4: directed steps, a reference memory
// model and a queue of expected read_d values popped after each edge.
module tb_sram_256x4;
  logic clk;
  logic rst_n;

  int total;
  int bad;

  logic [3:0] model [256];
  logic [3:0] exp_q [$];

  sram_256x4_if #(.DATA_W(4), .ADDR_W(8)) bus ();

  sram_256x4 #(.DATA_W(4), .ADDR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 20 ns clock.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model[i] = 4'h0;
  endtask

  // One access cycle: drive after a falling edge, push the expected value,
  // then pop and compare #1 after the rising edge.
  task automatic cyc(input string tag, input logic w, input logic [7:0] a, input logic [3:0] d);
    logic [3:0] e;
    bus.w_en    = w;
    bus.addr_in = a;
    bus.dat_in  = d;
    if (w) begin
      model[a] = d;
      exp_q.push_back(d);
    end else begin
      exp_q.push_back(model[a]);
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty observed=%h expected=<entry>", tag, bus.read_d);
    end else begin
      e = exp_q.pop_front();
      check(tag, bus.read_d, e);
    end
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_clear();
    rst_n       = 1'b0;
    bus.w_en    = 1'b0;
    bus.addr_in = 8'h00;
    bus.dat_in  = 4'h0;

    // 1. Reset state; a write attempted while reset is held is ignored.
    #1;
    check("reset_read_d", bus.read_d, 4'h0);
    @(negedge clk);
    bus.w_en    = 1'b1;
    bus.addr_in = 8'h30;
    bus.dat_in  = 4'h7;
    @(posedge clk);
    #1;
    check("reset_hold_read_d", bus.read_d, 4'h0);
    @(negedge clk);
    bus.w_en = 1'b0;
    rst_n    = 1'b1;
    cyc("rst_rd_00", 1'b0, 8'h00, 4'h0);
    cyc("rst_rd_7f", 1'b0, 8'h7F, 4'h0);
    cyc("rst_rd_ff", 1'b0, 8'hFF, 4'h0);
    cyc("rst_rd_30", 1'b0, 8'h30, 4'h0);

    // 2. Write pattern, back-to-back, then read back in order.
    cyc("wr_05", 1'b1, 8'h05, 4'h1);
    cyc("wr_06", 1'b1, 8'h06, 4'h2);
    cyc("wr_35", 1'b1, 8'h35, 4'h3);
    cyc("wr_45", 1'b1, 8'h45, 4'h4);
    cyc("wr_01", 1'b1, 8'h01, 4'hF);
    cyc("wr_02", 1'b1, 8'h02, 4'hF);
    cyc("wr_03", 1'b1, 8'h03, 4'hF);
    cyc("wr_04", 1'b1, 8'h04, 4'hF);
    cyc("rd_05", 1'b0, 8'h05, 4'h0);
    cyc("rd_06", 1'b0, 8'h06, 4'h0);
    cyc("rd_35", 1'b0, 8'h35, 4'h0);
    cyc("rd_45", 1'b0, 8'h45, 4'h0);
    cyc("rd_01", 1'b0, 8'h01, 4'h0);
    cyc("rd_02", 1'b0, 8'h02, 4'h0);
    cyc("rd_03", 1'b0, 8'h03, 4'h0);
    cyc("rd_04", 1'b0, 8'h04, 4'h0);
    cyc("rd_00", 1'b0, 8'h00, 4'h0);

    // 5. Async reset pulse between edges clears read_d with no clock edge.
    #4;
    rst_n = 1'b0;
    #1;
    check("async_rst_read_d", bus.read_d, 4'h0);
    model_clear();
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    cyc("post_rst_rd_05", 1'b0, 8'h05, 4'h0);
    cyc("post_rst_rd_45", 1'b0, 8'h45, 4'h0);

    // 3. Write-through then read the same address.
    cyc("wt_wr_10", 1'b1, 8'h10, 4'hA);
    cyc("wt_rd_10", 1'b0, 8'h10, 4'h0);

    // 4. Overwrite and neighbour isolation.
    cyc("ow_wr_20a", 1'b1, 8'h20, 4'h5);
    cyc("ow_wr_20b", 1'b1, 8'h20, 4'hC);
    cyc("ow_wr_21",  1'b1, 8'h21, 4'h3);
    cyc("ow_rd_20",  1'b0, 8'h20, 4'h0);
    cyc("ow_rd_21",  1'b0, 8'h21, 4'h0);
    cyc("ow_rd_1f",  1'b0, 8'h1F, 4'h0);
    cyc("ow_rd_22",  1'b0, 8'h22, 4'h0);

    // Alternating write/read on one address.
    cyc("alt_wr_40", 1'b1, 8'h40, 4'h6);
    cyc("alt_rd_40", 1'b0, 8'h40, 4'h0);
    cyc("alt_wr_40b", 1'b1, 8'h40, 4'h9);
    cyc("alt_rd_40b", 1'b0, 8'h40, 4'h0);

    // 6. Boundary addresses, no aliasing.
    cyc("bd_wr_ff", 1'b1, 8'hFF, 4'h9);
    cyc("bd_wr_00", 1'b1, 8'h00, 4'h6);
    cyc("bd_rd_ff", 1'b0, 8'hFF, 4'h0);
    cyc("bd_rd_00", 1'b0, 8'h00, 4'h0);
    cyc("bd_rd_7f", 1'b0, 8'h7F, 4'h0);

    // Reset asserted before the edge of a pending write: write is lost.
    bus.w_en    = 1'b1;
    bus.addr_in = 8'h55;
    bus.dat_in  = 4'hB;
    rst_n       = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    check("rst_before_edge_read_d", bus.read_d, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("rst_lost_rd_55", 1'b0, 8'h55, 4'h0);
    cyc("rst_lost_rd_ff", 1'b0, 8'hFF, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
